// File: rtl/ysyx_22041207_shift_mul.sv
// ysyx_22041207_shift_mul: iterative shift-add multiplier with fixed N+1 cycle latency
module ysyx_22041207_shift_mul #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             mulw,
    input  logic [1:0]       mul_signed,
    output logic             mul_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} state_t;
    state_t               r_state, w_next;
    logic [2*WIDTH-1:0]   r_mcand, r_acc, w_prod;
    logic [WIDTH-1:0]     r_mplier, r_hi, r_lo;
    logic [WIDTH-1:0]     w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    logic [CW-1:0]        r_cnt, w_last;
    logic                 r_neg, r_word, r_out_valid, w_sa, w_sb, w_accept;

    assign mul_ready = (r_state == IDLE) & ~flush;
    assign w_accept  = mul_valid & mul_ready;
    assign out_valid = r_out_valid;
    assign result_hi = r_hi;
    assign result_lo = r_lo;
    assign w_last    = r_word ? CW'(31) : CW'(WIDTH - 1);
    assign w_prod    = r_neg ? -r_acc : r_acc;

    // operand sign detection and magnitude extraction; word ops sign-extend bit 31 first
    always_comb begin
        w_sa    = mul_signed[1] & (mulw ? multiplicand[31] : multiplicand[WIDTH-1]);
        w_sb    = (mul_signed == 2'b11) & (mulw ? multiplier[31] : multiplier[WIDTH-1]);
        w_a_ext = mulw ? {{(WIDTH-32){w_sa}}, multiplicand[31:0]} : multiplicand;
        w_b_ext = mulw ? {{(WIDTH-32){w_sb}}, multiplier[31:0]} : multiplier;
        w_a_mag = w_sa ? -w_a_ext : w_a_ext;
        w_b_mag = w_sb ? -w_b_ext : w_b_ext;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state logic; flush overrides every state
    always_comb begin
        w_next = r_state;
        if (flush) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    w_next = w_accept ? BUSY : IDLE;
                BUSY:    w_next = (r_cnt == w_last) ? SIGN : BUSY;
                SIGN:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    // datapath: latch magnitudes, shift-add one multiplier bit per cycle, commit signed result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_word      <= 1'b0;
            r_out_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= (r_state == SIGN) & ~flush;
            if (flush) r_cnt <= '0;
            else if (r_state == IDLE && w_accept) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_neg    <= w_sa ^ w_sb;
                r_word   <= mulw;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == BUSY) begin
                r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end else if (r_state == SIGN) begin
                r_hi <= r_word ? {{(WIDTH-32){w_prod[63]}}, w_prod[63:32]} : w_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_word ? {{(WIDTH-32){w_prod[31]}}, w_prod[31:0]} : w_prod[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22041207_shift_mul.sv
// tb_ysyx_22041207_shift_mul: scoreboard bench for the shift-add multiplier
module tb_ysyx_22041207_shift_mul;
    logic        clk, rst, mul_valid, flush, mulw, mul_ready, out_valid;
    logic [63:0] multiplicand, multiplier, result_hi, result_lo;
    logic [1:0]  mul_signed;
    int          checks = 0, errors = 0, cyc = 0;
    logic        prev_ov = 1'b0;
    logic [63:0] last_hi = '0, last_lo = '0;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    ysyx_22041207_shift_mul #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .mul_valid(mul_valid), .flush(flush),
        .multiplicand(multiplicand), .multiplier(multiplier), .mulw(mulw),
        .mul_signed(mul_signed), .mul_ready(mul_ready), .out_valid(out_valid),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: 128-bit arithmetic on sign/zero-extended operands
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] ms, input logic w);
        logic [127:0] x, y, p;
        if (w) begin
            x = ms[1] ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
            y = (ms == 2'b11) ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
            p = x * y;
            return {{32{p[63]}}, p[63:32], {32{p[31]}}, p[31:0]};
        end
        x = ms[1] ? {{64{a[63]}}, a} : {64'b0, a};
        y = (ms == 2'b11) ? {{64{b[63]}}, b} : {64'b0, b};
        return x * y;
    endfunction

    // monitor: pops the scoreboard on every out_valid pulse
    always @(negedge clk) begin
        if (rst) prev_ov <= 1'b0;
        else begin
            if (out_valid) begin
                chk("ov_single_cycle", {63'b0, prev_ov}, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got pulse at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_hi", result_hi, e.hi);
                    chk("result_lo", result_lo, e.lo);
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    last_hi <= e.hi;
                    last_lo <= e.lo;
                end
            end
            prev_ov <= out_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!mul_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {63'b0, mul_ready}, 64'd1);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] ms,
                         input logic w, input logic [63:0] eh, input logic [63:0] el);
        exp_t e;
        wait_ready();
        multiplicand = a;
        multiplier   = b;
        mul_signed   = ms;
        mulw         = w;
        mul_valid    = 1'b1;
        e.hi = eh;
        e.lo = el;
        e.lat = w ? 33 : 65;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        mul_valid    = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        mul_signed   = 2'($urandom);
        mulw         = 1'($urandom);
    endtask

    task automatic issue_rand(input logic [63:0] a, input logic [63:0] b,
                              input logic [1:0] ms, input logic w);
        logic [127:0] r;
        r = model(a, b, ms, w);
        issue(a, b, ms, w, r[127:64], r[63:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; mul_valid = 1'b0; mulw = 1'b0;
        mul_signed = 2'b00; multiplicand = '0; multiplier = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_hi", result_hi, 64'd0);
        chk("reset_lo", result_lo, 64'd0);
        rst = 1'b0;
        #1 chk("reset_ready", {63'b0, mul_ready}, 64'd1);
        // flush blocks acceptance in IDLE
        @(negedge clk);
        flush = 1'b1; mul_valid = 1'b1; multiplicand = 64'd7; multiplier = 64'd7;
        #1 chk("flush_ready_low", {63'b0, mul_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0; mul_valid = 1'b0;
        #1 chk("flush_not_accepted", {63'b0, mul_ready}, 64'd1);
        // directed vectors
        issue(64'd3, 64'd5, 2'b00, 1'b0, 64'd0, 64'd15);
        issue('1, '1, 2'b11, 1'b0, 64'd0, 64'd1);
        issue('1, '1, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        issue(64'h8000_0000_0000_0000, 64'd2, 2'b11, 1'b0, '1, 64'd0);
        issue(64'hFFFF_FFFF_FFFF_FFFE, '1, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2);
        issue(64'h0000_0001_7FFF_FFFF, 64'd2, 2'b11, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0,
              64'h4000_0000_0000_0000, 64'd0);
        issue(64'd0, 64'hDEAD_BEEF_0000_0001, 2'b01, 1'b0, 64'd0, 64'd0);
        // flush mid-operation: no pulse, results held, next op correct
        wait_ready();
        multiplicand = 64'd9; multiplier = 64'd9; mul_signed = 2'b00; mulw = 1'b0;
        mul_valid = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_hold_hi", result_hi, last_hi);
        chk("flush_hold_lo", result_lo, last_lo);
        @(negedge clk);
        issue(64'd6, 64'd7, 2'b00, 1'b0, 64'd0, 64'd42);
        // reset mid-BUSY
        wait_ready();
        multiplicand = 64'd11; multiplier = 64'd13; mul_valid = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ov", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_hi", result_hi, 64'd0);
        chk("rst_mid_lo", result_lo, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_mid_ready", {63'b0, mul_ready}, 64'd1);
        repeat (80) @(negedge clk);
        // random sweep against the reference model
        for (int i = 0; i < 16; i++)
            issue_rand({$urandom, $urandom}, {$urandom, $urandom}, 2'(i), 1'(i >> 2));
        issue_rand(64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 2'b11, 1'b1);
        issue_rand(64'h8000_0000_0000_0001, '1, 2'b10, 1'b0);
        begin
            int n = 0;
            while (sb.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
